// File: rtl/led_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl_pkg
// Brief    : Shared register map, bit positions, FSM states and clamp rules
//            for the LED sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package led_seq_ctrl_pkg;

   // Register word addresses
   localparam logic [3:0] c_addr_ctrl    = 4'd0;
   localparam logic [3:0] c_addr_static  = 4'd1;
   localparam logic [3:0] c_addr_dwell   = 4'd2;
   localparam logic [3:0] c_addr_len     = 4'd3;
   localparam logic [3:0] c_addr_status  = 4'd4;
   localparam logic [3:0] c_addr_pattern = 4'd8;

   // CTRL bit positions
   localparam int c_ctrl_run_bit    = 0;
   localparam int c_ctrl_loop_bit   = 1;
   localparam int c_ctrl_irq_en_bit = 2;

   // STATUS bit positions
   localparam int c_status_busy_bit = 0;
   localparam int c_status_done_bit = 1;
   localparam int c_status_idx_lsb  = 4;

   // Sequencer state
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

   // Zero or oversize lengths mean "the whole table"
   function automatic logic [3:0] eff_len(input logic [3:0] len, input int depth);
      if (len == 4'd0 || int'(len) > depth)
         return 4'(depth);
      else
         return len;
   endfunction

   // Counter reload value for a step: max(dwell,1) - 1
   function automatic logic [31:0] dwell_reload(input logic [31:0] dwell);
      if (dwell == 32'd0)
         return 32'd0;
      else
         return dwell - 32'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/led_seq_timer.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_timer
// Brief    : Dwell down-counter with synchronous load and terminal count.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_timer #(
   parameter int DWELL_W = 24
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [DWELL_W-1:0] load_value,
   input  logic               enable,
   output logic               tc
);

   logic [DWELL_W-1:0] r_cnt;

   // Load wins over counting; the counter parks at zero until reloaded
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_cnt <= '0;
      else if (load)
         r_cnt <= load_value;
      else if (enable && r_cnt != '0)
         r_cnt <= r_cnt - 1'b1;
   end

   assign tc = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : led_seq_ctrl
// Brief    : Avalon-MM LED sequencer: static output register in idle, timed
//            pattern-table playback (one-shot or looping) when running.
// Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
   import led_seq_ctrl_pkg::*;
#(
   parameter int LED_W   = 10,
   parameter int DEPTH   = 8,
   parameter int DWELL_W = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [LED_W-1:0] out_port,
   output logic             irq
);

   seq_state_t         r_state;
   logic               r_loop;
   logic               r_irq_en;
   logic               r_done;
   logic [2:0]         r_idx;
   logic [LED_W-1:0]   r_static;
   logic [DWELL_W-1:0] r_dwell;
   logic [3:0]         r_len;
   logic [LED_W-1:0]   r_pattern [DEPTH];

   logic               w_wr;
   logic               w_ctrl_wr;
   logic               w_start;
   logic               w_stop;
   logic               w_tc;
   logic [3:0]         w_len_eff;
   logic               w_last;
   logic               w_boundary;
   logic               w_advance;
   logic               w_wrap;
   logic               w_finish;
   logic               w_busy;
   logic [DWELL_W-1:0] w_reload;

   assign w_wr      = chipselect && !write_n;
   assign w_ctrl_wr = w_wr && (address == c_addr_ctrl);
   assign w_busy    = (r_state == ST_RUN);

   // A run=1 write only starts from idle; in RUN it just updates the mode bits
   assign w_start   = w_ctrl_wr &&  writedata[c_ctrl_run_bit] && !w_busy;
   assign w_stop    = w_ctrl_wr && !writedata[c_ctrl_run_bit] &&  w_busy;

   // LEN is sampled live at the boundary, so shrinking it below idx+1 ends the run here
   assign w_len_eff  = eff_len(r_len, DEPTH);
   assign w_last     = ({1'b0, r_idx} + 4'd1) >= w_len_eff;
   assign w_boundary = w_busy && w_tc && !w_stop;
   assign w_advance  = w_boundary && !w_last;
   assign w_wrap     = w_boundary &&  w_last &&  r_loop;
   assign w_finish   = w_boundary &&  w_last && !r_loop;
   assign w_reload   = DWELL_W'(dwell_reload(32'(r_dwell)));

   led_seq_timer #(
      .DWELL_W (DWELL_W)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (w_start || w_advance || w_wrap),
      .load_value (w_reload),
      .enable     (w_busy),
      .tc         (w_tc)
   );

   // Sequencer FSM with mode bits, step index and sticky done flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_loop   <= 1'b0;
         r_irq_en <= 1'b0;
         r_done   <= 1'b0;
         r_idx    <= 3'd0;
      end else begin
         if (w_ctrl_wr) begin
            r_loop   <= writedata[c_ctrl_loop_bit];
            r_irq_en <= writedata[c_ctrl_irq_en_bit];
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state <= ST_RUN;
                  r_idx   <= 3'd0;
               end
            end
            ST_RUN: begin
               if (w_stop)
                  r_state <= ST_IDLE;
               else if (w_advance)
                  r_idx <= r_idx + 3'd1;
               else if (w_wrap)
                  r_idx <= 3'd0;
               else if (w_finish)
                  r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         // Completion beats a simultaneous write-1-to-clear
         if (w_finish)
            r_done <= 1'b1;
         else if (w_wr && address == c_addr_status && writedata[c_status_done_bit])
            r_done <= 1'b0;
      end
   end

   // Plain configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_static <= '0;
         r_dwell  <= '0;
         r_len    <= '0;
      end else if (w_wr) begin
         if (address == c_addr_static) r_static <= writedata[LED_W-1:0];
         if (address == c_addr_dwell)  r_dwell  <= writedata[DWELL_W-1:0];
         if (address == c_addr_len)    r_len    <= writedata[3:0];
      end
   end

   for (genvar n = 0; n < DEPTH; n++) begin : g_pattern
      // One pattern table entry, writable at any time
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)
            r_pattern[n] <= '0;
         else if (w_wr && address == 4'(8 + n))
            r_pattern[n] <= writedata[LED_W-1:0];
      end
   end

   assign out_port = w_busy ? r_pattern[r_idx] : r_static;
   assign irq      = r_done && r_irq_en;

   // Zero-wait read mux; unmapped addresses return 0
   always_comb begin
      readdata = '0;
      case (address)
         c_addr_ctrl: begin
            readdata[c_ctrl_run_bit]    = w_busy;
            readdata[c_ctrl_loop_bit]   = r_loop;
            readdata[c_ctrl_irq_en_bit] = r_irq_en;
         end
         c_addr_static: readdata[LED_W-1:0]   = r_static;
         c_addr_dwell:  readdata[DWELL_W-1:0] = r_dwell;
         c_addr_len:    readdata[3:0]         = r_len;
         c_addr_status: begin
            readdata[c_status_busy_bit] = w_busy;
            readdata[c_status_done_bit] = r_done;
            readdata[c_status_idx_lsb +: 3] = r_idx;
         end
         default: begin
            if (address[3] && int'(address[2:0]) < DEPTH)
               readdata[LED_W-1:0] = r_pattern[address[2:0]];
         end
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_seq_ctrl
// Brief    : Self-checking bench for led_seq_ctrl against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [9:0]  out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [9:0] pat [8];
   logic [9:0] static_val;

   always #5 clk = ~clk;

   led_seq_ctrl #(
      .LED_W   (10),
      .DEPTH   (8),
      .DWELL_W (24)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle, optionally carrying a bus write; returns at posedge+1
   task automatic tick(input bit we, input logic [3:0] a, input logic [31:0] d);
      if (we) begin
         chipselect = 1'b1;
         write_n    = 1'b0;
         address    = a;
         writedata  = d;
      end
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d);
      tick(1'b1, a, d);
   endtask

   task automatic rd(input logic [3:0] a, output logic [31:0] d);
      address = a;
      #1;
      d = readdata;
   endtask

   task automatic load_table();
      for (int i = 0; i < 8; i++) wr(4'(8 + i), 32'(pat[i]));
   endtask

   // Model: cycle t of a run shows entry t/dwell; after len*dwell cycles it is STATIC
   task automatic run_oneshot(input int dwell, input int len, input bit irq_en, input string tag);
      int d;
      int l;
      logic [31:0] r;
      d = (dwell == 0) ? 1 : dwell;
      l = (len == 0 || len > 8) ? 8 : len;
      wr(4'd2, 32'(dwell));
      wr(4'd3, 32'(len));
      wr(4'd0, {29'd0, irq_en, 1'b0, 1'b1});
      for (int t = 0; t < l * d; t++) begin
         chk({tag, "_out"}, 32'(out_port), 32'(pat[t / d]));
         rd(4'd4, r);
         chk({tag, "_idx"}, 32'(r[6:4]), 32'(t / d));
         chk({tag, "_busy"}, 32'(r[0]), 32'd1);
         tick(1'b0, 4'd0, 32'd0);
      end
      chk({tag, "_end_out"}, 32'(out_port), 32'(static_val));
      chk({tag, "_end_irq"}, 32'(irq), 32'(irq_en));
      rd(4'd4, r);
      chk({tag, "_end_done"}, 32'(r[1:0]), 32'd2);
      rd(4'd0, r);
      chk({tag, "_end_run"}, 32'(r[0]), 32'd0);
      wr(4'd4, 32'd2);
      chk({tag, "_clr_irq"}, 32'(irq), 32'd0);
      rd(4'd4, r);
      chk({tag, "_clr_done"}, 32'(r[1]), 32'd0);
   endtask

   initial begin
      logic [31:0] r;
      logic [9:0]  exp_q [$];
      int d;
      int l;

      reset_n    = 1'b0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      address    = 4'd0;
      writedata  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;

      // Reset state
      chk("rst_out", 32'(out_port), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      for (int a = 0; a < 9; a++) begin
         rd(4'(a), r);
         chk("rst_read", r, 32'd0);
      end
      tick(1'b0, 4'd0, 32'd0);

      // Static register mode
      static_val = 10'h2A5;
      wr(4'd1, 32'h2A5);
      chk("static_out", 32'(out_port), 32'h2A5);
      rd(4'd1, r);
      chk("static_read", r, 32'h2A5);
      chk("static_irq", 32'(irq), 32'd0);

      // Basic one-shot with irq
      pat[0] = 10'h001; pat[1] = 10'h002; pat[2] = 10'h004; pat[3] = 10'h008;
      for (int i = 4; i < 8; i++) pat[i] = 10'($urandom);
      load_table();
      rd(4'd9, r);
      chk("pat_read", r, 32'(pat[1]));
      run_oneshot(3, 4, 1'b1, "oneshot");

      // Looping: wraps without a gap, stop returns to STATIC without done
      wr(4'd2, 32'd3);
      wr(4'd3, 32'd4);
      wr(4'd0, 32'h3);
      for (int t = 0; t < 29; t++) begin
         chk("loop_out", 32'(out_port), 32'(pat[(t / 3) % 4]));
         tick(1'b0, 4'd0, 32'd0);
      end
      wr(4'd0, 32'd0);
      chk("loop_stop_out", 32'(out_port), 32'(static_val));
      rd(4'd4, r);
      chk("loop_stop_status", 32'(r[1:0]), 32'd0);

      // DWELL=0, LEN=0: eight single-cycle steps
      for (int i = 0; i < 8; i++) pat[i] = 10'($urandom);
      load_table();
      run_oneshot(0, 0, 1'b0, "fast");

      // Randomised one-shot runs
      repeat (4) begin
         for (int i = 0; i < 8; i++) pat[i] = 10'($urandom);
         static_val = 10'($urandom);
         load_table();
         wr(4'd1, 32'(static_val));
         run_oneshot(int'($urandom_range(0, 4)), int'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), "rand");
      end

      // Randomised looping run
      d = int'($urandom_range(1, 3));
      r = 32'($urandom_range(0, 15));
      l = (r == 0 || r > 8) ? 8 : int'(r);
      wr(4'd2, 32'(d));
      wr(4'd3, r);
      wr(4'd0, 32'h3);
      for (int t = 0; t < 2 * l * d + 2; t++) begin
         chk("rloop_out", 32'(out_port), 32'(pat[(t / d) % l]));
         tick(1'b0, 4'd0, 32'd0);
      end
      wr(4'd0, 32'd0);
      chk("rloop_stop", 32'(out_port), 32'(static_val));

      // DWELL rewritten during step 1 applies from step 2
      wr(4'd2, 32'd3);
      wr(4'd3, 32'd4);
      wr(4'd0, 32'd1);
      exp_q = {};
      for (int s = 0; s < 4; s++)
         repeat ((s < 2) ? 3 : 5) exp_q.push_back(pat[s]);
      for (int t = 0; t < exp_q.size(); t++) begin
         chk("dwchg_out", 32'(out_port), 32'(exp_q[t]));
         tick(t == 3, 4'd2, 32'd5);
      end
      chk("dwchg_end", 32'(out_port), 32'(static_val));
      wr(4'd4, 32'd2);

      // LEN lowered to 1 while idx=2 ends the run at that step
      wr(4'd2, 32'd2);
      wr(4'd3, 32'd4);
      wr(4'd0, 32'd1);
      exp_q = {};
      for (int s = 0; s < 3; s++) repeat (2) exp_q.push_back(pat[s]);
      for (int t = 0; t < exp_q.size(); t++) begin
         chk("lenchg_out", 32'(out_port), 32'(exp_q[t]));
         tick(t == 4, 4'd3, 32'd1);
      end
      chk("lenchg_end", 32'(out_port), 32'(static_val));
      rd(4'd4, r);
      chk("lenchg_done", 32'(r[1:0]), 32'd2);
      wr(4'd4, 32'd2);

      // done-clear coinciding with completion: set wins
      wr(4'd2, 32'd1);
      wr(4'd3, 32'd1);
      wr(4'd0, 32'd1);
      chk("coinc_run", 32'(out_port), 32'(pat[0]));
      tick(1'b1, 4'd4, 32'd2);
      chk("coinc_out", 32'(out_port), 32'(static_val));
      rd(4'd4, r);
      chk("coinc_done", 32'(r[1]), 32'd1);
      wr(4'd4, 32'd2);

      // Asynchronous reset during a long run
      wr(4'd2, 32'd100);
      wr(4'd3, 32'd0);
      wr(4'd0, 32'h5);
      repeat (3) tick(1'b0, 4'd0, 32'd0);
      chk("arst_pre", 32'(out_port), 32'(pat[0]));
      reset_n = 1'b0;
      #1;
      chk("arst_out", 32'(out_port), 32'd0);
      chk("arst_irq", 32'(irq), 32'd0);
      rd(4'd4, r);
      chk("arst_status", r, 32'd0);
      rd(4'd0, r);
      chk("arst_ctrl", r, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_after_out", 32'(out_port), 32'd0);
      rd(4'd4, r);
      chk("arst_after_status", r, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
